// File: rtl/io_ports_pkg.sv
// Shared register map, status layout and bus-request type for the io_ports block.
package io_ports_pkg;

  localparam logic [3:0] OFF_CHG  = 4'h8;
  localparam logic [3:0] OFF_STAT = 4'h9;
  localparam logic [3:0] OFF_TXD  = 4'hA;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_CNT   = 4;

  typedef struct packed {
    logic       hit;
    logic       rd;
    logic       wr;
    logic [3:0] off;
  } io_req_t;

  function automatic logic [7:0] pack_stat(input logic [3:0] cnt, input logic ovf,
                                           input logic empty, input logic full);
    logic [7:0] s;
    s                  = '0;
    s[STAT_FULL]       = full;
    s[STAT_EMPTY]      = empty;
    s[STAT_OVF]        = ovf;
    s[STAT_CNT +: 4]   = cnt;
    return s;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Circular-buffer TX FIFO; a push into a full FIFO is accepted only when a pop frees a slot the same cycle.
module io_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                    gclk,
  input  logic                    grst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic                  do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // storage needs no reset; only pointers and count define validity
  always_ff @(posedge gclk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_ports.sv
// Windowed I/O decoder: synchronised input ports, output latches, sticky change flags
// and a buffered TX channel toward the console.
module io_ports
  import io_ports_pkg::*;
#(
  parameter int         DATA_WIDTH = 8,
  parameter int         NUM_PORTS  = 2,
  parameter logic [7:0] BASE_ADDR  = 8'h00,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic                            i_clk,
  input  logic                            i_nRst,
  input  logic [DATA_WIDTH-1:0]           i_bus,
  output logic [DATA_WIDTH-1:0]           o_bus,
  output logic                            o_busOe,
  input  logic                            i_ioSelect,
  input  logic [7:0]                      i_ioAddress,
  input  logic                            i_ioNOE,
  input  logic                            i_ioNWE,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_portIn,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] o_portOut,
  output logic [DATA_WIDTH-1:0]           o_txData,
  output logic                            o_txValid,
  input  logic                            i_txReady,
  output logic                            o_changeIrq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  io_req_t                              req;
  logic                                 nwe_last;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] pin_in, sync1, sync2, prev, latch;
  logic [NUM_PORTS-1:0]                 chg_flags, chg_set, chg_clr;
  logic                                 irq_q, ovf_q;
  logic                                 push_req, pop, fifo_full, fifo_empty;
  logic [CW-1:0]                        fifo_count;
  logic [DATA_WIDTH-1:0]                fifo_rdata, rdata;

  assign pin_in    = i_portIn;
  assign o_portOut = latch;

  always_comb begin
    req.off = i_ioAddress[3:0];
    req.hit = i_ioSelect && (i_ioAddress[7:4] == BASE_ADDR[7:4]);
    req.rd  = req.hit && !i_ioNOE;
    // one strobe per NWE low assertion: only the first low cycle counts
    req.wr  = req.hit && !i_ioNWE && nwe_last;
  end

  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) nwe_last <= 1'b1;
    else         nwe_last <= i_ioNWE;
  end

  always_comb begin
    chg_set = '0;
    chg_clr = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      chg_set[k] = (prev[k] != sync2[k]);
      chg_clr[k] = req.wr && (req.off == OFF_CHG) && i_bus[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      sync1     <= '0;
      sync2     <= '0;
      prev      <= '0;
      latch     <= '0;
      chg_flags <= '0;
      irq_q     <= 1'b0;
    end else begin
      sync1     <= pin_in;
      sync2     <= sync1;
      prev      <= sync2;
      // a fresh change wins over a same-cycle clear
      chg_flags <= (chg_flags & ~chg_clr) | chg_set;
      irq_q     <= |chg_flags;
      for (int k = 0; k < NUM_PORTS; k++)
        if (req.wr && (req.off == 4'(k))) latch[k] <= i_bus;
    end
  end

  assign o_changeIrq = irq_q;

  assign pop      = o_txValid && i_txReady;
  assign push_req = req.wr && (req.off == OFF_TXD);

  io_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .gclk   (i_clk),
    .grst_n (i_nRst),
    .push   (push_req),
    .pop    (pop),
    .wdata  (i_bus),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign o_txValid = !fifo_empty;
  assign o_txData  = o_txValid ? fifo_rdata : '0;

  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst)
      ovf_q <= 1'b0;
    else if (push_req && fifo_full && !pop)
      ovf_q <= 1'b1;
    else if (req.wr && (req.off == OFF_STAT) && i_bus[STAT_OVF])
      ovf_q <= 1'b0;
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_PORTS; k++)
      if (req.off == 4'(k)) rdata = sync2[k];
    if (req.off == OFF_CHG)  rdata = DATA_WIDTH'(chg_flags);
    if (req.off == OFF_STAT) rdata = DATA_WIDTH'(pack_stat(4'(fifo_count), ovf_q, fifo_empty, fifo_full));
  end

  assign o_busOe = req.rd;
  assign o_bus   = o_busOe ? rdata : '0;

endmodule

// File: tb/tb_io_ports.sv
// Randomised and directed bench for io_ports against a cycle-level reference model.
module tb_io_ports;
  localparam int         DW   = 8;
  localparam int         NP   = 2;
  localparam int         D    = 4;
  localparam logic [7:0] BASE = 8'h00;

  logic               i_clk = 1'b0, i_nRst = 1'b0;
  logic [DW-1:0]      i_bus = '0, o_bus;
  logic               o_busOe;
  logic               i_ioSelect = 1'b0, i_ioNOE = 1'b1, i_ioNWE = 1'b1;
  logic [7:0]         i_ioAddress = '0;
  logic [NP*DW-1:0]   i_portIn = '0, o_portOut;
  logic [DW-1:0]      o_txData;
  logic               o_txValid, i_txReady = 1'b0, o_changeIrq;

  always #5 i_clk = ~i_clk;

  io_ports #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .BASE_ADDR(BASE), .FIFO_DEPTH(D)) dut (
    .i_clk(i_clk), .i_nRst(i_nRst), .i_bus(i_bus), .o_bus(o_bus), .o_busOe(o_busOe),
    .i_ioSelect(i_ioSelect), .i_ioAddress(i_ioAddress), .i_ioNOE(i_ioNOE), .i_ioNWE(i_ioNWE),
    .i_portIn(i_portIn), .o_portOut(o_portOut), .o_txData(o_txData), .o_txValid(o_txValid),
    .i_txReady(i_txReady), .o_changeIrq(o_changeIrq)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: ph[0] = pins seen at the latest edge; readable value lags by one more edge
  logic [NP*DW-1:0] ph [3];
  logic [NP-1:0]    m_flags;
  logic             m_irq, m_ovf, m_nwe_prev;
  logic [DW-1:0]    m_lat [NP];
  logic [DW-1:0]    m_q [$];

  task automatic m_reset();
    for (int i = 0; i < 3; i++) ph[i] = '0;
    for (int k = 0; k < NP; k++) m_lat[k] = '0;
    m_flags = '0; m_irq = 1'b0; m_ovf = 1'b0; m_nwe_prev = 1'b1;
    m_q.delete();
  endtask

  function automatic logic [DW-1:0] m_rd(input int off);
    if (off < NP)   return ph[1][off*DW +: DW];
    if (off == 8)   return DW'(m_flags);
    if (off == 9)   return {4'(m_q.size()), 1'b0, m_ovf, m_q.size() == 0, m_q.size() == D};
    return '0;
  endfunction

  function automatic logic [NP*DW-1:0] m_out();
    logic [NP*DW-1:0] v;
    for (int k = 0; k < NP; k++) v[k*DW +: DW] = m_lat[k];
    return v;
  endfunction

  task automatic m_edge();
    logic hit, wr, pop;
    int off;
    logic [NP-1:0] setm, clr;
    hit = i_ioSelect && (i_ioAddress[7:4] == BASE[7:4]);
    off = int'(i_ioAddress[3:0]);
    wr  = hit && !i_ioNWE && m_nwe_prev;
    pop = (m_q.size() > 0) && i_txReady;
    for (int k = 0; k < NP; k++) setm[k] = (ph[1][k*DW +: DW] != ph[2][k*DW +: DW]);
    clr = (wr && off == 8) ? i_bus[NP-1:0] : '0;
    m_irq   = |m_flags;
    m_flags = (m_flags & ~clr) | setm;
    if (wr && off < NP) m_lat[off] = i_bus;
    if (pop) void'(m_q.pop_front());
    if (wr && off == 10) begin
      if (m_q.size() < D) m_q.push_back(i_bus);
      else                m_ovf = 1'b1;
    end
    if (wr && off == 9 && i_bus[2]) m_ovf = 1'b0;
    ph[2] = ph[1]; ph[1] = ph[0]; ph[0] = i_portIn;
    m_nwe_prev = i_ioNWE;
  endtask

  // one clock: check read path, advance model and DUT, check registered outputs
  task automatic cyc();
    logic eoe;
    #1;
    eoe = i_ioSelect && (i_ioAddress[7:4] == BASE[7:4]) && !i_ioNOE;
    chk("busOe", o_busOe, eoe);
    chk("bus", o_bus, eoe ? m_rd(int'(i_ioAddress[3:0])) : '0);
    m_edge();
    @(posedge i_clk); #1;
    chk("portOut", o_portOut, m_out());
    chk("txValid", o_txValid, m_q.size() > 0);
    if (m_q.size() > 0) chk("txData", o_txData, m_q[0]);
    chk("irq", o_changeIrq, m_irq);
  endtask

  task automatic idle();
    i_ioSelect = 1'b0; i_ioNWE = 1'b1; i_ioNOE = 1'b1;
  endtask

  task automatic wr_io(input logic [7:0] a, input logic [7:0] d);
    i_ioSelect = 1'b1; i_ioAddress = a; i_bus = d; i_ioNOE = 1'b1; i_ioNWE = 1'b0;
    cyc();
    idle();
    cyc();
  endtask

  task automatic rd_io(input logic [7:0] a, input logic [7:0] e, input string tag);
    i_ioSelect = 1'b1; i_ioAddress = a; i_ioNOE = 1'b0; i_ioNWE = 1'b1;
    #1;
    chk(tag, o_bus, e);
    chk({tag, "_oe"}, o_busOe, 1'b1);
    cyc();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tx_exp [4];
    i_portIn = 16'hA55A;
    m_reset();
    #12;
    chk("rst_portOut", o_portOut, 0);
    chk("rst_txValid", o_txValid, 0);
    chk("rst_irq", o_changeIrq, 0);
    chk("rst_busOe", o_busOe, 0);
    @(posedge i_clk); #1;
    i_nRst = 1'b1;
    m_reset();

    cyc(); cyc();
    rd_io(8'h00, 8'h5A, "sync_lat2");

    // write with NWE held low three cycles, data changing after the first
    i_ioSelect = 1'b1; i_ioAddress = 8'h01; i_bus = 8'h3C; i_ioNWE = 1'b0;
    cyc();
    chk("wr_first", o_portOut[15:8], 8'h3C);
    i_bus = 8'hFF;
    cyc(); cyc();
    chk("wr_once", o_portOut[15:8], 8'h3C);
    idle(); cyc();

    // change detect timing
    repeat (4) cyc();
    wr_io(8'h08, 8'hFF);
    repeat (3) cyc();
    chk("irq_clear", o_changeIrq, 0);
    i_portIn = 16'hA55B;
    cyc(); cyc(); cyc();
    chk("irq_lag", o_changeIrq, 0);
    rd_io(8'h08, 8'h01, "chg_3rd");
    chk("irq_4th", o_changeIrq, 1);
    i_portIn = 16'hA55A;
    cyc(); cyc();
    wr_io(8'h08, 8'h01);
    rd_io(8'h08, 8'h01, "chg_setwins");
    wr_io(8'h08, 8'h01);
    rd_io(8'h08, 8'h00, "chg_cleared");

    // FIFO fill, overflow, drain
    i_txReady = 1'b0;
    for (int i = 0; i < 4; i++) wr_io(8'h0A, 8'h41 + 8'(i));
    rd_io(8'h09, 8'h41, "stat_full");
    wr_io(8'h0A, 8'h45);
    rd_io(8'h09, 8'h45, "stat_ovf");
    i_txReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("tx_seq", o_txData, 8'h41 + 8'(i));
      cyc();
    end
    chk("tx_drained", o_txValid, 0);
    i_txReady = 1'b0;
    rd_io(8'h09, 8'h06, "stat_empty");
    wr_io(8'h09, 8'h04);
    rd_io(8'h09, 8'h02, "stat_ovfclr");

    // push while full with a same-cycle pop
    for (int i = 0; i < 4; i++) wr_io(8'h0A, 8'h61 + 8'(i));
    i_txReady = 1'b1; i_ioSelect = 1'b1; i_ioAddress = 8'h0A; i_bus = 8'h50; i_ioNWE = 1'b0;
    chk("full_head", o_txData, 8'h61);
    cyc();
    idle(); i_txReady = 1'b0;
    cyc();
    rd_io(8'h09, 8'h41, "stat_pushpop");
    tx_exp = '{8'h62, 8'h63, 8'h64, 8'h50};
    i_txReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("tx_pushpop", o_txData, tx_exp[i]);
      cyc();
    end
    i_txReady = 1'b0;

    // async reset mid-drain, with NWE held low across release
    wr_io(8'h00, 8'h99);
    for (int i = 0; i < 3; i++) wr_io(8'h0A, 8'h71 + 8'(i));
    i_portIn = i_portIn ^ 16'h0001;
    repeat (5) cyc();
    chk("pre_irq", o_changeIrq, 1);
    i_txReady = 1'b1;
    cyc();
    chk("pre_valid", o_txValid, 1);
    #2;
    i_nRst = 1'b0;
    #1;
    chk("arst_portOut", o_portOut, 0);
    chk("arst_txValid", o_txValid, 0);
    chk("arst_txData", o_txData, 0);
    chk("arst_irq", o_changeIrq, 0);
    chk("arst_busOe", o_busOe, 0);
    chk("arst_bus", o_bus, 0);
    i_txReady = 1'b0;
    i_ioSelect = 1'b1; i_ioAddress = 8'h00; i_bus = 8'h77; i_ioNOE = 1'b1; i_ioNWE = 1'b0;
    @(posedge i_clk); #1;
    i_nRst = 1'b1;
    m_reset();
    cyc();
    chk("nwe_held", o_portOut[7:0], 8'h77);
    i_bus = 8'h88;
    cyc();
    chk("nwe_held_once", o_portOut[7:0], 8'h77);
    idle(); cyc();

    // unmapped offset and out-of-window address
    rd_io(8'h0F, 8'h00, "unmapped");
    i_ioSelect = 1'b1; i_ioAddress = 8'h10; i_ioNOE = 1'b0;
    #1;
    chk("window_oe", o_busOe, 0);
    chk("window_bus", o_bus, 0);
    cyc();
    idle();
    wr_io(8'h10, 8'h55);
    chk("window_wr", o_portOut[7:0], 8'h77);

    // randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [3:0] off;
      int r;
      if ($urandom_range(7) == 0) i_portIn = 16'($urandom);
      r = $urandom_range(5);
      case (r)
        0: off = 4'h0;
        1: off = 4'h1;
        2: off = 4'h8;
        3: off = 4'h9;
        4: off = 4'hA;
        default: off = 4'($urandom_range(15));
      endcase
      i_ioSelect  = ($urandom_range(3) != 0);
      i_ioAddress = ($urandom_range(7) == 0) ? {4'h1, off} : {BASE[7:4], off};
      i_ioNOE     = 1'($urandom_range(1));
      i_ioNWE     = ($urandom_range(2) != 0);
      i_bus       = 8'($urandom);
      i_txReady   = ($urandom_range(2) == 0);
      cyc();
    end
    idle();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
